data_access_ctrl: RTL

Sequencing controller between the memory pipeline stage and the data-side bus/cache port. It latches one load/store request, drives a two-phase `addr_ok`/`data_ok` handshake, and stalls the pipeline until the access completes. It also serializes CACHE-instruction maintenance operations onto a separate request/done port. Only one transaction is outstanding at a time.

---
 rtl/data_access_pkg.sv | 38 +++
 rtl/data_access_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/data_access_pkg.sv
// Shared types and constants for the data-side access controller.
// The COP state only exists when DATA_ACCESS_CACHE_OP_EN is defined.
package data_access_pkg;

    typedef enum logic [2:0] {
        DAC_IDLE = 3'd0,
        DAC_ADDR = 3'd1,
        DAC_DATA = 3'd2,
`ifdef DATA_ACCESS_CACHE_OP_EN
        DAC_COP  = 3'd3,
`endif
        DAC_DONE = 3'd4
    } dac_state_t;

    typedef enum logic [1:0] {
        COP_NONE      = 2'b00,
        COP_INST_INV  = 2'b01,
        COP_DATA_WB   = 2'b10,
        COP_INDEX_INV = 2'b11
    } cop_type_t;

    localparam logic [2:0] DSZ_BYTE = 3'd0;
    localparam logic [2:0] DSZ_HALF = 3'd1;
    localparam logic [2:0] DSZ_WORD = 3'd2;

    // Index invalidate wins over data writeback, which wins over instruction invalidate.
    function automatic cop_type_t cop_select(input logic inst_inv,
                                             input logic data_wb,
                                             input logic index_inv);
        cop_type_t sel;
        sel = COP_NONE;
        if (index_inv)     sel = COP_INDEX_INV;
        else if (data_wb)  sel = COP_DATA_WB;
        else if (inst_inv) sel = COP_INST_INV;
        return sel;
    endfunction

endpackage

// File: rtl/data_access_ctrl.sv
// Single-outstanding load/store sequencer with an addr_ok/data_ok bus handshake.
// Define DATA_ACCESS_CACHE_OP_EN to enable the cache-operation request port.
module data_access_ctrl
    import data_access_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_en,
    input  logic [3:0]        req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_size,
    input  logic              cop_inst_inv,
    input  logic              cop_data_wb,
    input  logic              cop_index_inv,
    input  logic              flush,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [3:0]        bus_wstrb,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [2:0]        bus_size,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [31:0]       bus_rdata,
    output logic              op_req,
    output logic [1:0]        op_type,
    output logic [ADDR_W-1:0] op_addr,
    input  logic              op_done
);

    dac_state_t        state;
    logic              cancel;
    logic              is_load;
    logic [3:0]        wen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        size_q;
    logic [31:0]       rdata_q;

`ifdef DATA_ACCESS_CACHE_OP_EN
    cop_type_t         op_type_q;
    logic [ADDR_W-1:0] op_addr_q;
    logic              cop_any;

    assign cop_any = cop_inst_inv | cop_data_wb | cop_index_inv;
`else
    logic unused_cop;
    logic cop_any;

    assign unused_cop = ^{cop_inst_inv, cop_data_wb, cop_index_inv, op_done};
    assign cop_any    = 1'b0;
`endif

    // NOTE: every register, including the request latches, is reset so a
    // mid-transaction reset leaves the bus fields at zero, not stale values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= DAC_IDLE;
            cancel  <= 1'b0;
            is_load <= 1'b0;
            wen_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            rdata_q <= '0;
`ifdef DATA_ACCESS_CACHE_OP_EN
            op_type_q <= COP_NONE;
            op_addr_q <= '0;
`endif
        end else begin
            case (state)
                DAC_IDLE: begin
                    cancel <= 1'b0;
`ifdef DATA_ACCESS_CACHE_OP_EN
                    if (cop_any && !flush) begin
                        op_type_q <= cop_select(cop_inst_inv, cop_data_wb, cop_index_inv);
                        op_addr_q <= req_addr;
                        is_load   <= 1'b0;
                        state     <= DAC_COP;
                    end else
`endif
                    if (req_en && !flush) begin
                        addr_q  <= req_addr;
                        wen_q   <= req_wen;
                        wdata_q <= req_wdata;
                        size_q  <= req_size;
                        is_load <= (req_wen == 4'b0000);
                        state   <= DAC_ADDR;
                    end
                end
                DAC_ADDR: begin
                    if (flush) cancel <= 1'b1;
                    if (bus_addr_ok) begin
                        if (bus_data_ok) begin
                            if (is_load) rdata_q <= bus_rdata;
                            state <= DAC_DONE;
                        end else begin
                            state <= DAC_DATA;
                        end
                    end
                end
                DAC_DATA: begin
                    if (flush) cancel <= 1'b1;
                    if (bus_data_ok) begin
                        if (is_load) rdata_q <= bus_rdata;
                        state <= DAC_DONE;
                    end
                end
`ifdef DATA_ACCESS_CACHE_OP_EN
                DAC_COP: begin
                    if (flush) cancel <= 1'b1;
                    if (op_done) state <= DAC_DONE;
                end
`endif
                DAC_DONE: begin
                    state <= DAC_IDLE;
                end
                default: state <= DAC_IDLE;
            endcase
        end
    end

    // Only the IDLE-state stall looks at live inputs; elsewhere it follows state.
    always_comb begin
        stall = 1'b0;
        case (state)
            DAC_IDLE: stall = (req_en | cop_any) & ~flush;
            DAC_ADDR,
            DAC_DATA: stall = 1'b1;
`ifdef DATA_ACCESS_CACHE_OP_EN
            DAC_COP:  stall = 1'b1;
`endif
            default:  stall = 1'b0;
        endcase
    end

    assign bus_req     = (state == DAC_ADDR);
    assign bus_wr      = |wen_q;
    assign bus_wstrb   = wen_q;
    assign bus_addr    = addr_q;
    assign bus_wdata   = wdata_q;
    assign bus_size    = size_q;
    assign rdata       = rdata_q;
    assign rdata_valid = (state == DAC_DONE) & is_load & ~cancel;

`ifdef DATA_ACCESS_CACHE_OP_EN
    assign op_req  = (state == DAC_COP);
    assign op_type = op_type_q;
    assign op_addr = op_addr_q;
`else
    assign op_req  = 1'b0;
    assign op_type = 2'b00;
    assign op_addr = '0;
`endif

endmodule
